branch_predictor: RTL and testbench

- Dynamic branch predictor for the 5-stage RISC-V pipeline; sits upstream of the IF/ID register, beside the PC stage.
- Given the fetch PC, it returns a same-cycle taken/target prediction from a direct-mapped table. Each entry holds a 2-bit saturating counter, a tag, a target and a valid bit.
- The ID stage reports each resolved branch back into the block.
- The block registers a one-cycle mispredict pulse, which the flush logic uses to squash IF.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tag/target table.
// Define BP_STATS_EN to add update and mispredict statistics counters.
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] INIT_CTR   = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pred_pc_i,
    output logic        pred_hit_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_pred_taken_i,
    input  logic [31:0] upd_pred_target_i,
    input  logic        upd_is_jalr_i,
`ifdef BP_STATS_EN
    output logic [31:0] stat_updates_o,
    output logic [31:0] stat_mispred_o,
`endif
    output logic        mispredict_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [INDEX_BITS-1:0] pidx;
    logic [TAG_W-1:0]      ptag;
    logic [INDEX_BITS-1:0] uidx;
    logic [TAG_W-1:0]      utag;
    logic                  upd_en;
    logic                  upd_hit;
    logic                  upd_alloc;
    logic                  mis_nxt;
    logic [1:0]            ctr_nxt;
    logic                  unused_ok;

    assign pidx = pred_pc_i[INDEX_BITS+1:2];
    assign ptag = pred_pc_i[31:INDEX_BITS+2];
    assign uidx = upd_pc_i[INDEX_BITS+1:2];
    assign utag = upd_pc_i[31:INDEX_BITS+2];

    assign unused_ok = ^{pred_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads the registered table only, so same-cycle updates are not bypassed
    assign pred_hit_o    = valid_q[pidx] && (tag_q[pidx] == ptag);
    assign pred_taken_o  = pred_hit_o && ctr_q[pidx][1];
    assign pred_target_o = pred_hit_o ? tgt_q[pidx] : 32'd0;

    assign upd_en    = start_i && upd_valid_i;
    assign upd_hit   = valid_q[uidx] && (tag_q[uidx] == utag);
    assign upd_alloc = !upd_hit && upd_taken_i && !upd_is_jalr_i;

    assign mis_nxt = upd_en &&
                     ((upd_taken_i != upd_pred_taken_i) ||
                      (upd_taken_i && upd_pred_taken_i &&
                       (upd_target_i != upd_pred_target_i)));

    always_comb begin
        ctr_nxt = ctr_q[uidx];
        if (upd_taken_i) begin
            if (ctr_nxt != 2'b11)
                ctr_nxt = ctr_nxt + 2'd1;
        end else if (ctr_nxt != 2'b00) begin
            ctr_nxt = ctr_nxt - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_CTR;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (upd_en) begin
            unique case (1'b1)
                upd_hit: begin
                    ctr_q[uidx] <= ctr_nxt;
                    // Indirect targets are never cached
                    if (upd_taken_i && !upd_is_jalr_i)
                        tgt_q[uidx] <= upd_target_i;
                end
                upd_alloc: begin
                    valid_q[uidx] <= 1'b1;
                    tag_q[uidx]   <= utag;
                    ctr_q[uidx]   <= 2'b10;
                    tgt_q[uidx]   <= upd_target_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            mispredict_o <= 1'b0;
        else
            mispredict_o <= mis_nxt;
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_updates_o <= '0;
            stat_mispred_o <= '0;
        end else begin
            if (upd_en)
                stat_updates_o <= stat_updates_o + 32'd1;
            if (mis_nxt)
                stat_mispred_o <= stat_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vector table, corner sequences,
// and randomized traffic against a table-level reference model.
module tb_branch_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_pred_taken_i = 1'b0;
    logic [31:0] upd_pred_target_i = '0;
    logic        upd_is_jalr_i = 1'b0;
    logic        mispredict_o;
`ifdef BP_STATS_EN
    logic [31:0] stat_updates_o;
    logic [31:0] stat_mispred_o;
`endif

    branch_predictor dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .pred_pc_i         (pred_pc_i),
        .pred_hit_o        (pred_hit_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .upd_is_jalr_i     (upd_is_jalr_i),
`ifdef BP_STATS_EN
        .stat_updates_o    (stat_updates_o),
        .stat_mispred_o    (stat_mispred_o),
`endif
        .mispredict_o      (mispredict_o)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: one record per table slot, plain integers
    bit          m_val [64];
    int unsigned m_tag [64];
    int unsigned m_tgt [64];
    int          m_ctr [64];
    int unsigned m_upd;
    int unsigned m_mis;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        jalr;
        logic [31:0] lpc;
        logic        emis;
        logic        ehit;
        logic        etk;
        logic [31:0] etgt;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic j);
        start_i = s;
        upd_valid_i = v;
        upd_pc_i = pc;
        upd_taken_i = tk;
        upd_target_i = tgt;
        upd_pred_taken_i = ptk;
        upd_pred_target_i = ptgt;
        upd_is_jalr_i = j;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_val[i] = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = 0;
            m_ctr[i] = 1;
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        model_clear();
    endtask

    task automatic m_look(input logic [31:0] pc, output logic h,
                          output logic t, output logic [31:0] g);
        int unsigned i;
        i = (pc / 4) % 64;
        h = m_val[i] && (m_tag[i] == pc / 256);
        t = h && (m_ctr[i] >= 2);
        g = h ? m_tgt[i] : 0;
    endtask

    task automatic m_update(input logic s, input logic v, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt,
                            input logic j, output logic mis);
        int unsigned i;
        bit hit;
        mis = 1'b0;
        if (!(s && v))
            return;
        m_upd++;
        mis = (tk != ptk) || (tk && ptk && tgt != ptgt);
        if (mis)
            m_mis++;
        i = (pc / 4) % 64;
        hit = m_val[i] && (m_tag[i] == pc / 256);
        if (hit) begin
            m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (tk && !j)
                m_tgt[i] = tgt;
        end else if (tk && !j) begin
            m_val[i] = 1'b1;
            m_tag[i] = pc / 256;
            m_ctr[i] = 2;
            m_tgt[i] = tgt;
        end
    endtask

    function automatic logic [31:0] rand_pc();
        int unsigned tags [4];
        int unsigned idxs [4];
        tags = '{32'h100, 32'h101, 32'h7ff, 32'h0};
        idxs = '{0, 1, 2, 63};
        return (tags[$urandom_range(3)] << 8) | (idxs[$urandom_range(3)] << 2)
               | $urandom_range(3);
    endfunction

    initial begin
        logic        eh, et, em;
        logic [31:0] eg;
        logic        s, v, tk, ptk, j;
        logic [31:0] pc, tgt, ptgt;

        vt[0] = '{32'h00010008, 1, 32'h00010020, 0, 32'h0, 0,
                  32'h00010008, 1, 1, 1, 32'h00010020};
        vt[1] = '{32'h00010008, 0, 32'h0, 1, 32'h00010020, 0,
                  32'h00010008, 1, 1, 0, 32'h00010020};
        vt[2] = '{32'h00010008, 0, 32'h0, 0, 32'h0, 0,
                  32'h00010008, 0, 1, 0, 32'h00010020};
        vt[3] = '{32'h00010008, 0, 32'h0, 0, 32'h0, 0,
                  32'h00010008, 0, 1, 0, 32'h00010020};
        vt[4] = '{32'h00010108, 1, 32'h00000040, 0, 32'h0, 0,
                  32'h00010008, 1, 0, 0, 32'h0};
        vt[5] = '{32'h00010010, 1, 32'h00000500, 0, 32'h0, 1,
                  32'h00010010, 1, 0, 0, 32'h0};
        vt[6] = '{32'h00010108, 1, 32'h00000040, 1, 32'h00000040, 0,
                  32'h00010108, 0, 1, 1, 32'h00000040};
        vt[7] = '{32'h00010108, 1, 32'h00000080, 1, 32'h00000040, 0,
                  32'h00010108, 1, 1, 1, 32'h00000080};

        @(posedge clk_i);
        #1;
        do_reset();
        start_i = 1'b1;
        pred_pc_i = 32'h00010008;
        #1;
        chk("reset_hit", pred_hit_o, 0);
        chk("reset_taken", pred_taken_o, 0);
        chk("reset_target", pred_target_o, 0);
        chk("reset_mis", mispredict_o, 0);

        // Directed vector table
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, vt[k].pc, vt[k].tk, vt[k].tgt, vt[k].ptk,
                  vt[k].ptgt, vt[k].jalr);
            pred_pc_i = vt[k].lpc;
            cyc();
            chk($sformatf("vec%0d_mis", k), mispredict_o, vt[k].emis);
            chk($sformatf("vec%0d_hit", k), pred_hit_o, vt[k].ehit);
            chk($sformatf("vec%0d_taken", k), pred_taken_o, vt[k].etk);
            chk($sformatf("vec%0d_target", k), pred_target_o, vt[k].etgt);
            upd_valid_i = 1'b0;
            cyc();
            chk($sformatf("vec%0d_pulse", k), mispredict_o, 0);
        end

        // Asynchronous reset between clock edges
        pred_pc_i = 32'h00010108;
        #1;
        chk("prerst_hit", pred_hit_o, 1);
        rst_i = 1'b0;
        #1;
        chk("async_rst_hit", pred_hit_o, 0);
        chk("async_rst_target", pred_target_o, 0);
        rst_i = 1'b1;
        model_clear();

        // Same-cycle lookup and update of one entry
        cyc();
        drive(1, 1, 32'h00020000, 1, 32'h00001234, 0, 32'h0, 0);
        pred_pc_i = 32'h00020000;
        #1;
        chk("same_cyc_old_hit", pred_hit_o, 0);
        chk("same_cyc_old_tgt", pred_target_o, 0);
        cyc();
        upd_valid_i = 1'b0;
        #1;
        chk("same_cyc_new_hit", pred_hit_o, 1);
        chk("same_cyc_new_tgt", pred_target_o, 32'h00001234);
        chk("same_cyc_mis", mispredict_o, 1);

        // Five updates with two mispredicts, then a gated update
        do_reset();
        pred_pc_i = 32'h00030004;
        drive(1, 1, 32'h00030004, 1, 32'h100, 0, 32'h0, 0);
        cyc();
        chk("st1_mis", mispredict_o, 1);
        drive(1, 1, 32'h00030004, 1, 32'h100, 1, 32'h100, 0);
        cyc();
        chk("st2_mis", mispredict_o, 0);
        cyc();
        chk("st3_mis", mispredict_o, 0);
        drive(1, 1, 32'h00030004, 0, 32'h0, 0, 32'h0, 0);
        cyc();
        chk("st4_mis", mispredict_o, 0);
        drive(1, 1, 32'h00030004, 0, 32'h0, 1, 32'h100, 0);
        cyc();
        chk("st5_mis", mispredict_o, 1);
`ifdef BP_STATS_EN
        chk("stat_updates", stat_updates_o, 5);
        chk("stat_mispred", stat_mispred_o, 2);
`endif
        drive(0, 1, 32'h00030004, 1, 32'h200, 0, 32'h0, 0);
        cyc();
        chk("gated_mis", mispredict_o, 0);
        chk("gated_taken", pred_taken_o, 0);
        chk("gated_target", pred_target_o, 32'h100);
`ifdef BP_STATS_EN
        chk("gated_updates", stat_updates_o, 5);
        chk("gated_mispred", stat_mispred_o, 2);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            pc = rand_pc();
            s = ($urandom_range(7) != 0);
            v = ($urandom_range(3) != 0);
            tk = $urandom_range(1);
            j = ($urandom_range(7) == 0);
            tgt = $urandom;
            ptk = $urandom_range(1);
            m_look(pc, eh, et, eg);
            ptgt = $urandom_range(1) ? eg : tgt;
            drive(s, v, pc, tk, tgt, ptk, ptgt, j);
            pred_pc_i = $urandom_range(1) ? pc : rand_pc();
            #1;
            m_look(pred_pc_i, eh, et, eg);
            chk("rnd_hit", pred_hit_o, eh);
            chk("rnd_taken", pred_taken_o, et);
            chk("rnd_target", pred_target_o, eg);
            m_update(s, v, pc, tk, tgt, ptk, ptgt, j, em);
            cyc();
            chk("rnd_mis", mispredict_o, em);
        end
`ifdef BP_STATS_EN
        chk("rnd_stat_updates", stat_updates_o, m_upd);
        chk("rnd_stat_mispred", stat_mispred_o, m_mis);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
